// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer between MEM and the data cache.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

package store_buffer_pkg;

  localparam int unsigned SB_NUM_ENTRIES = 4;
  localparam int unsigned SB_WORD_SIZE   = 32;
  localparam int unsigned SB_ROB_W       = `ROB_ENTRY_WIDTH;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic                    valid;
    logic                    committed;
    logic [SB_WORD_SIZE-1:0] addr;
    logic [SB_WORD_SIZE-1:0] data;
    logic [1:0]              size;
    logic [SB_ROB_W-1:0]     rob_id;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Youngest-match store-to-load forwarding selector; scans entries oldest to youngest
// relative to tail so the youngest matching entry is the last one written.
module store_buffer_fwd
  import store_buffer_pkg::*;
#(
  parameter int unsigned N         = SB_NUM_ENTRIES,
  parameter int unsigned WORD_SIZE = SB_WORD_SIZE,
  localparam int unsigned IW       = $clog2(N)
) (
  input  sb_entry_t             entries [N],
  input  logic [IW-1:0]         tail,
  input  logic [WORD_SIZE-1:0]  ld_addr,
  output logic                  fwd_hit,
  output logic                  fwd_stall,
  output logic [WORD_SIZE-1:0]  fwd_data
);

  logic [IW-1:0] idx;
  logic          unused_fwd;

  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    idx       = '0;
    for (int k = int'(N); k >= 1; k--) begin
      idx = tail - IW'(k);
      if (entries[idx].valid &&
          entries[idx].addr[WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2]) begin
        if (entries[idx].size == SZ_W) begin
          fwd_hit   = 1'b1;
          fwd_stall = 1'b0;
          fwd_data  = entries[idx].data;
        end else begin
          fwd_hit   = 1'b0;
          fwd_stall = 1'b1;
          fwd_data  = '0;
        end
      end
    end
  end

  always_comb begin
    unused_fwd = ^ld_addr[1:0];
    for (int i = 0; i < int'(N); i++) begin
      unused_fwd = unused_fwd ^ entries[i].committed ^ (^entries[i].rob_id) ^
                   (^entries[i].addr[1:0]);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: holds executed stores until ROB permission, drains them to the
// D-cache one per cycle, forwards word data to loads, and drops uncommitted stores on flush.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned N               = SB_NUM_ENTRIES,
  parameter int unsigned WORD_SIZE       = SB_WORD_SIZE,
  parameter int unsigned ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [WORD_SIZE-1:0]       st_addr,
  input  logic [WORD_SIZE-1:0]       st_data,
  input  logic [1:0]                 st_size,
  input  logic [ROB_ENTRY_WIDTH-1:0] st_rob_id,
  output logic                       full,
  input  logic                       sb_store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0] sb_rob_id,
  input  logic                       flush,
  input  logic [WORD_SIZE-1:0]       ld_addr,
  output logic                       fwd_hit,
  output logic [WORD_SIZE-1:0]       fwd_data,
  output logic                       fwd_stall,
  output logic                       dc_req,
  output logic [WORD_SIZE-1:0]       dc_addr,
  output logic [WORD_SIZE-1:0]       dc_data,
  output logic [1:0]                 dc_size,
  input  logic                       dc_ready,
  output logic                       empty
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = IW + 1;

  sb_entry_t     entries_q [N];
  sb_entry_t     entries_d [N];
  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, ccount_q, ccount_d;
  logic          alloc, xfer, perm_hit;
  logic [IW-1:0] perm_idx;
  sb_entry_t     head_ent;

  assign full     = (count_q == CW'(N));
  assign empty    = (count_q == '0);
  assign head_ent = entries_q[head_q];
  assign dc_req   = head_ent.valid && head_ent.committed;
  assign dc_addr  = head_ent.addr;
  assign dc_data  = head_ent.data;
  assign dc_size  = head_ent.size;
  assign alloc    = st_valid && !full;
  assign xfer     = dc_req && dc_ready;

  // Only uncommitted entries are candidates so a repeated tag cannot double-count.
  always_comb begin
    perm_hit = 1'b0;
    perm_idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (sb_store_permission && entries_q[i].valid && !entries_q[i].committed &&
          entries_q[i].rob_id == sb_rob_id) begin
        perm_hit = 1'b1;
        perm_idx = IW'(i);
      end
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    ccount_d  = ccount_q;
    if (perm_hit) begin
      entries_d[perm_idx].committed = 1'b1;
      ccount_d = ccount_d + CW'(1);
    end
    if (xfer) begin
      entries_d[head_q] = '0;
      head_d   = head_q + IW'(1);
      ccount_d = ccount_d - CW'(1);
    end
    if (flush) begin
      // Permission and drain above are already folded in, so survivors are exactly ccount_d.
      for (int i = 0; i < int'(N); i++) begin
        if (!entries_d[i].committed) entries_d[i] = '0;
      end
      tail_d  = head_d + ccount_d[IW-1:0];
      count_d = ccount_d;
    end else begin
      if (alloc) begin
        entries_d[tail_q] = '{valid: 1'b1, committed: 1'b0, addr: st_addr, data: st_data,
                              size: st_size, rob_id: st_rob_id};
        tail_d = tail_q + IW'(1);
      end
      count_d = count_q + CW'(alloc) - CW'(xfer);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N); i++) entries_q[i] <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ccount_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ccount_q  <= ccount_d;
    end
  end

  store_buffer_fwd #(
    .N         (N),
    .WORD_SIZE (WORD_SIZE)
  ) u_fwd (
    .entries   (entries_q),
    .tail      (tail_q),
    .ld_addr   (ld_addr),
    .fwd_hit   (fwd_hit),
    .fwd_stall (fwd_stall),
    .fwd_data  (fwd_data)
  );

endmodule
